// File: rtl/iter_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// iter_multiplier_pkg
// Shared definitions for the iterative shift-add multiplier:
//   - state_e   : FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   - WIDTH_DEF : default operand width
//   - CNT_W_DEF : step-counter width for the default operand width
//   - cnt_width : counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package iter_multiplier_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/iter_mult_step.sv
// -----------------------------------------------------------------------------
// iter_mult_step
// One combinational shift-add iteration: conditionally add the multiplicand
// into the upper accumulator (controlled by the LSB of the lower half), then
// shift the whole {acc_hi, acc_lo} right by one, moving the add carry into
// the top of acc_hi.
// Ports:
//   acc_hi    in  WIDTH+1  upper accumulator (carry bit included)
//   acc_lo    in  WIDTH    lower accumulator / remaining multiplier bits
//   mcand     in  WIDTH    multiplicand
//   nxt_hi    out WIDTH+1  upper accumulator after add and shift
//   nxt_lo    out WIDTH    lower accumulator after shift
// -----------------------------------------------------------------------------
module iter_mult_step
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] addend_s;
  logic [WIDTH:0] sum_s;

  // Add/shift datapath. acc_hi's MSB is always 0 on entry after a shift,
  // so the WIDTH+1-bit sum cannot overflow.
  always_comb begin
    addend_s = {(WIDTH + 1){1'b0}};
    if (acc_lo[0]) begin
      addend_s = {1'b0, mcand};
    end else begin
      addend_s = {(WIDTH + 1){1'b0}};
    end
    sum_s  = acc_hi + addend_s;
    nxt_hi = {1'b0, sum_s[WIDTH:1]};
    nxt_lo = {sum_s[0], acc_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/iter_multiplier.sv
// -----------------------------------------------------------------------------
// iter_multiplier
// Multi-cycle shift-add multiplier with start/busy/done handshake. A start
// accepted in IDLE or DONE is followed by WIDTH RUN cycles; done pulses for
// one cycle afterwards and the product registers hold until the next
// completion. Start is accepted in DONE, allowing back-to-back operations.
//
// Optional build macro: ITER_MULT_SIGNED_EN
//   defined   : op_signed=1 multiplies two's-complement operands (magnitudes
//               are multiplied, result negated when the signs differ)
//   undefined : op_signed ignored, every operation is unsigned
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous active-low reset
//   start       in   1      request, sampled only in IDLE or DONE
//   op_a        in   WIDTH  multiplicand
//   op_b        in   WIDTH  multiplier
//   op_signed   in   1      signed operation select
//   busy        out  1      high while running
//   done        out  1      one-cycle completion pulse
//   product_hi  out  WIDTH  upper half of last completed product
//   product_lo  out  WIDTH  lower half of last completed product
// -----------------------------------------------------------------------------
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [2*WIDTH-1:0]   PROD_ONE = {{(2 * WIDTH - 1){1'b0}}, 1'b1};

  state_e             state_r;
  logic [CNT_W-1:0]   ctr_r;
  logic [WIDTH:0]     acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [WIDTH-1:0]   mcand_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   prod_hi_r;
  logic [WIDTH-1:0]   prod_lo_r;
  logic               neg_r;

  logic [WIDTH:0]     nxt_hi_s;
  logic [WIDTH-1:0]   nxt_lo_s;
  logic [WIDTH-1:0]   cap_a_s;
  logic [WIDTH-1:0]   cap_b_s;
  logic               cap_neg_s;
  logic [2*WIDTH-1:0] raw_prod_s;
  logic [2*WIDTH-1:0] final_prod_s;
  logic               unused_nxt_msb_s;

  iter_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_hi (acc_hi_r),
    .acc_lo (acc_lo_r),
    .mcand  (mcand_r),
    .nxt_hi (nxt_hi_s),
    .nxt_lo (nxt_lo_s)
  );

  // After the last shift the carry slot of acc_hi is always empty.
  assign unused_nxt_msb_s = nxt_hi_s[WIDTH];
  assign raw_prod_s       = {nxt_hi_s[WIDTH-1:0], nxt_lo_s};

`ifdef ITER_MULT_SIGNED_EN
  // Operand capture: signed operands are reduced to magnitudes; the most
  // negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    cap_a_s   = op_a;
    cap_b_s   = op_b;
    cap_neg_s = 1'b0;
    if (op_signed) begin
      cap_a_s   = op_a[WIDTH-1] ? (~op_a + {{(WIDTH - 1){1'b0}}, 1'b1}) : op_a;
      cap_b_s   = op_b[WIDTH-1] ? (~op_b + {{(WIDTH - 1){1'b0}}, 1'b1}) : op_b;
      cap_neg_s = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end else begin
      cap_neg_s = 1'b0;
    end
  end

  // Result sign restore on completion.
  always_comb begin
    final_prod_s = raw_prod_s;
    if (neg_r) begin
      final_prod_s = ~raw_prod_s + PROD_ONE;
    end else begin
      final_prod_s = raw_prod_s;
    end
  end
`else
  logic unused_signed_s;
  logic [2*WIDTH-1:0] unused_one_s;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    cap_a_s      = op_a;
    cap_b_s      = op_b;
    cap_neg_s    = 1'b0;
    final_prod_s = raw_prod_s;
  end

  assign unused_signed_s = op_signed ^ neg_r;
  assign unused_one_s    = PROD_ONE;
`endif

  // Control FSM, step counter, accumulator and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      ctr_r     <= {CNT_W{1'b0}};
      acc_hi_r  <= {(WIDTH + 1){1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      prod_hi_r <= {WIDTH{1'b0}};
      prod_lo_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand_r  <= cap_a_s;
            acc_lo_r <= cap_b_s;
            acc_hi_r <= {(WIDTH + 1){1'b0}};
            neg_r    <= cap_neg_s;
            ctr_r    <= CNT_LOAD;
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_hi_r <= nxt_hi_s;
          acc_lo_r <= nxt_lo_s;
          ctr_r    <= ctr_r - CNT_ONE;
          // Final step: publish the shifted accumulator on the same edge.
          if (ctr_r == CNT_ONE) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            prod_hi_r <= final_prod_s[2*WIDTH-1:WIDTH];
            prod_lo_r <= final_prod_s[WIDTH-1:0];
          end else begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign product_hi = prod_hi_r;
  assign product_lo = prod_lo_r;

endmodule

// File: doc/iter_multiplier.md
Name: iter_multiplier

Overview:
Multi-cycle shift-add multiplier for the 16-bit datapath. Takes two WIDTH-bit operands and produces a 2*WIDTH-bit product in hi/lo result registers using a start/busy/done handshake. Sits directly upstream of the writeback result mux: product_lo and product_hi feed spare mux inputs selected by the controller once done pulses. Saves a combinational array multiplier at the cost of WIDTH+1 cycles of latency.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
op_a  input  WIDTH  multiplicand, captured on accepted start
op_b  input  WIDTH  multiplier, captured on accepted start
op_signed  input  1  treat operands as two's complement (see Optional Feature); captured with operands
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; product valid from this cycle on
product_hi  output  WIDTH  upper half of last completed product
product_lo  output  WIDTH  lower half of last completed product

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, product_hi=0, product_lo=0, counter=0, internal accumulator cleared. Release is synchronous to clk.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE: start=1 at edge -> capture op_a, op_b, op_signed; acc_hi=0 (WIDTH+1 bits, carry included); acc_lo=op_b; counter=WIDTH; go RUN. start=0 -> stay.
- RUN, each edge: if acc_lo[0] then acc_hi += multiplicand; then {acc_hi, acc_lo} shifts right 1 (carry bit moves into acc_hi MSB); counter -= 1. When counter reaches 1 on this edge's evaluation -> go DONE, loading product_hi/product_lo from the final shifted accumulator on the same edge.
- Latency: start sampled at edge E0; RUN spans edges E1..E16 (WIDTH edges); done=1 for the cycle after E16. product valid at the same time as done and held until the next completion.
- start while busy: ignored, not queued. Operand changes while busy: no effect.
- DONE lasts exactly one cycle. start=1 in DONE is accepted like IDLE, giving DONE -> RUN directly for back-to-back ops; otherwise DONE -> IDLE.
- Arithmetic: unsigned, exact 2*WIDTH result, no overflow possible. Carry out of the add is never lost (WIDTH+1-bit acc_hi).
- Reset mid-operation: aborts immediately; no done pulse; product registers return to 0.

Optional Feature:
ITER_MULT_SIGNED_EN. Defined: when captured op_signed=1, operands are replaced by their magnitudes at capture (WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1)), a neg flag = sign_a XOR sign_b is stored, and the 2*WIDTH result is two's-complement negated when product registers load on entry to DONE. Latency is unchanged. Undefined: op_signed is ignored, all operations unsigned, no negation logic synthesised.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE, 2-bit encoding), WIDTH default constant, counter width constant $clog2(WIDTH+1).
- One sub-module, iter_mult_step: combinational single-step add/shift (inputs acc_hi, acc_lo, multiplicand; outputs next acc_hi, acc_lo). Top keeps the FSM, counter, and registers.

Test Plan:
- reset low then high; start with op_a=3, op_b=5 -> busy 16 cycles, done pulse on the 17th cycle after the start edge, product_hi=0x0000, product_lo=0x000F.
- op_a=0xFFFF, op_b=0xFFFF, op_signed=0 -> product_hi=0xFFFE, product_lo=0x0001.
- op_a=0xFFFF, op_b=0xFFFF, op_signed=1 -> with macro 0x0000/0x0001; without macro 0xFFFE/0x0001. With macro: 0x8000*0x8000 signed -> 0x4000/0x0000; 0x0007*0xFFFD signed -> 0xFFFF/0xFFEB.
- 2*3 in flight; assert start with op_a=9, op_b=9 at RUN cycle 5 -> ignored, result 0x0000/0x0006; start=1 held during the DONE cycle with 4*4 -> immediate RUN, next done gives 0x0000/0x0010.
- reset pulsed low at RUN cycle 8 -> busy=0, done never pulses, product 0x0000/0x0000; a new start afterwards completes normally.
